serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing A − B − bin, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the area-minimal subtraction counterpart to the parallel adder datapath. It serves multi-cycle arithmetic paths that trade latency for gate count. A start/busy/done handshake frames each operation, and results hold stable until the next operation completes.

---
 rtl/serial_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_subtractor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor computing A - B - bin. It processes one bit
// per clock, LSB first, through a single full-subtractor cell with a
// registered borrow. A start/busy/done handshake frames each operation.
// Results stay stable until the next operation completes.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, the Ovf port and its operand-MSB flops are present.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only while idle
//   A       in   [WIDTH] minuend, captured on the accepted start edge
//   B       in   [WIDTH] subtrahend, captured on the accepted start edge
//   bin     in   borrow-in, captured on the accepted start edge
//   busy    out  high while an operation is in progress
//   done    out  one-cycle completion pulse
//   Diff    out  [WIDTH] (A - B - bin) mod 2^WIDTH
//   Borrow  out  unsigned borrow-out of the MSB stage
//   Ovf     out  signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] res_sh_reg;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_reg;
  logic             b_msb_reg;
`endif

  // Full-subtractor cell on the current LSBs.
  logic             d_next;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  assign d_next   = a_sh_reg[0] ^ b_sh_reg[0] ^ br_reg;
  assign br_next  = (~a_sh_reg[0] & b_sh_reg[0]) |
                    (~(a_sh_reg[0] ^ b_sh_reg[0]) & br_reg);
  // Each new difference bit enters at the MSB, so after WIDTH shifts
  // bit 0 has reached position 0.
  assign res_next = {d_next, res_sh_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      Diff       <= '0;
      Borrow     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_reg  <= 1'b0;
      b_msb_reg  <= 1'b0;
      Ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= A;
            b_sh_reg  <= B;
            br_reg    <= bin;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_reg <= A[WIDTH-1];
            b_msb_reg <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          res_sh_reg <= res_next;
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          br_reg     <= br_next;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            // On the last edge the result register is not yet updated,
            // so take the freshly shifted value directly.
            Diff      <= res_next;
            Borrow    <= br_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
            // d_next is the MSB of the difference on this edge.
            Ovf       <= (a_msb_reg ^ b_msb_reg) & (d_next ^ a_msb_reg);
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic        Borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic        Ovf;
`endif

  serial_subtractor #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .Diff   (Diff),
    .Borrow (Borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .Ovf    (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        brw;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a start request; returns just after the accepting edge E0.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
    A     = a;
    B     = b;
    bin   = bi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  int          cyc;
  int          ndone;
  int          first;
  logic [15:0] prev_d;
  logic        prev_b;

  initial begin
    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    bin   = 1'b0;
    #12;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_diff", int'(Diff), 0);
    chk("reset_borrow", int'(Borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset_ovf", int'(Ovf), 0);
`endif
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    prev_d = '0;
    prev_b = 1'b0;
    for (int v = 0; v < 9; v++) begin
      start_op(vecs[v].a, vecs[v].b, vecs[v].bi);
      chk("busy_after_start", int'(busy), 1);
      @(posedge clk);
      #1;
      chk("diff_hold_in_run", int'(Diff), int'(prev_d));
      chk("borrow_hold_in_run", int'(Borrow), int'(prev_b));
      wait_done(cyc);
      chk("latency", (cyc < 0) ? -1 : cyc + 1, 16);
      chk("diff", int'(Diff), int'(vecs[v].d));
      chk("borrow", int'(Borrow), int'(vecs[v].brw));
`ifdef SERIAL_SUB_OVF_EN
      chk("ovf", int'(Ovf), int'(vecs[v].ovf));
`endif
      chk("busy_at_done", int'(busy), 0);
      $display("vec %0d: A=%h B=%h bin=%0d -> Diff=%h Borrow=%0d latency=%0d",
               v, vecs[v].a, vecs[v].b, vecs[v].bi, Diff, Borrow, (cyc < 0) ? -1 : cyc + 1);
      @(posedge clk);
      #1;
      chk("done_one_cycle", int'(done), 0);
      prev_d = vecs[v].d;
      prev_b = vecs[v].brw;
    end

    // start during RUN must be ignored
    start_op(16'h0005, 16'h0003, 1'b0);
    ndone = 0;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin
        A     = 16'hFFFF;
        B     = 16'h0001;
        bin   = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (first < 0) first = i;
      end
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_latency", first, 16);
    chk("ignored_start_diff", int'(Diff), 16'h0002);
    $display("busy-start: dones=%0d first=%0d Diff=%h", ndone, first, Diff);

    // back-to-back issue: start in the done cycle
    start_op(16'h0010, 16'h0001, 1'b0);
    wait_done(cyc);
    chk("b2b_first_latency", cyc, 16);
    chk("b2b_first_diff", int'(Diff), 16'h000F);
    start_op(16'h0020, 16'h0003, 1'b0);
    chk("b2b_second_busy", int'(busy), 1);
    wait_done(cyc);
    chk("b2b_second_latency", cyc, 16);
    chk("b2b_second_diff", int'(Diff), 16'h001D);
    $display("back-to-back: second latency=%0d Diff=%h", cyc, Diff);

    // asynchronous reset in the middle of an operation
    start_op(16'h00FF, 16'h000F, 1'b0);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_diff", int'(Diff), 0);
    chk("midrst_borrow", int'(Borrow), 0);
    #10 rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    start_op(16'h00FF, 16'h000F, 1'b0);
    wait_done(cyc);
    chk("postrst_latency", cyc, 16);
    chk("postrst_diff", int'(Diff), 16'h00F0);
    chk("postrst_borrow", int'(Borrow), 0);
    $display("reset mid-op: spurious dones=%0d, new Diff=%h", ndone, Diff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
